// File: rtl/gb_frame_scaler_if.sv
// gb_frame_scaler_if: VGA coordinate in / scaled pixel out bus between timing generator and scaler
interface gb_frame_scaler_if #(
   parameter int PX_W = 2
);
   logic [9:0]      vga_x;
   logic [9:0]      vga_y;
   logic            vga_active;
   logic [PX_W-1:0] pixel_out;
   logic            pixel_in_window;
   logic            pixel_active;
   modport master (output vga_x, vga_y, vga_active, input pixel_out, pixel_in_window, pixel_active);
   modport slave  (input vga_x, vga_y, vga_active, output pixel_out, pixel_in_window, pixel_active);
endinterface

// File: rtl/gb_frame_scaler.sv
// gb_frame_scaler: double-buffered GB capture framebuffer with integer upscaling into the VGA window
module gb_frame_scaler #(
   parameter int SRC_H   = 160,
   parameter int SRC_V   = 144,
   parameter int PX_W    = 2,
   parameter int SCALE   = 2,
   parameter int DST_H   = 640,
   parameter int DST_V   = 480,
   parameter int ADDR_W  = 15,
   parameter int TIMEOUT = 1048576
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            gb_px_clk,
   input  logic            gb_hsync,
   input  logic            gb_vsync,
   input  logic [PX_W-1:0] gb_dat,
   gb_frame_scaler_if.slave vga,
   output logic            gb_on,
   output logic            frame_swap,
   output logic [7:0]      frames_dropped,
   output logic            gb_hsync_sync
);
   localparam int OFF_X = (DST_H - SRC_H*SCALE)/2;
   localparam int OFF_Y = (DST_V - SRC_V*SCALE)/2;
   localparam int SH    = $clog2(SCALE);
   localparam int LAST  = SRC_H*SRC_V - 1;
   localparam int CW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} wr_state_t;

   logic [2:0]        px_s, vs_s;
   logic [1:0]        hs_s;
   logic [PX_W-1:0]   dat_s1, dat_s2;
   logic              strobe, vsync_rise, lost, swap_pt, do_swap;
   wr_state_t         state, state_nx;
   logic              we, set_pend, drop, pending, disp_bank;
   logic [ADDR_W-1:0] wr_addr, waddr, rd_addr;
   logic [CW-1:0]     idle_cnt;
   logic [PX_W-1:0]   mem [0:2**(ADDR_W+1)-1];
   logic [PX_W-1:0]   rd_q;
   logic [9:0]        dx, dy, sx, sy;
   logic              in_x, in_y;
   logic              win1, chk1, on1, act1, win2, chk2, on2, act2;

   assign strobe        = px_s[2] & ~px_s[1];
   assign vsync_rise    = ~vs_s[2] & vs_s[1];
   assign gb_hsync_sync = hs_s[1];
   assign lost          = ~strobe & (idle_cnt == CW'(TIMEOUT - 1));
   assign swap_pt       = ~vga.vga_active & (vga.vga_x == 10'd0) & (vga.vga_y == 10'(DST_V));
   assign do_swap       = swap_pt & (pending | set_pend) & ~lost;
   assign waddr         = (state == ARMED) ? '0 : wr_addr;

   // synchronise the asynchronous GB pins; data lags one stage less so it lines up with the strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         px_s   <= '0;
         vs_s   <= '0;
         hs_s   <= '0;
         dat_s1 <= '0;
         dat_s2 <= '0;
      end else begin
         px_s   <= {px_s[1:0], gb_px_clk};
         vs_s   <= {vs_s[1:0], gb_vsync};
         hs_s   <= {hs_s[0], gb_hsync};
         dat_s1 <= gb_dat;
         dat_s2 <= dat_s1;
      end
   end

   // writer next state: arm on vsync, fill the back bank, hand it over as pending
   always_comb begin
      state_nx = state;
      we       = 1'b0;
      set_pend = 1'b0;
      drop     = 1'b0;
      case (state)
         IDLE:  if (vsync_rise) begin
                   drop     = pending;
                   state_nx = pending ? IDLE : ARMED;
                end
         ARMED: if (!vsync_rise && strobe) begin
                   we       = 1'b1;
                   state_nx = WRITE;
                end
         WRITE: if (vsync_rise) state_nx = ARMED;
                else if (strobe) begin
                   we       = 1'b1;
                   set_pend = (wr_addr == ADDR_W'(LAST));
                   state_nx = set_pend ? DONE : WRITE;
                end
         default: state_nx = IDLE;
      endcase
      if (lost) begin
         state_nx = IDLE;
         we       = 1'b0;
         set_pend = 1'b0;
         drop     = 1'b0;
      end
   end

   // writer state, bank ownership, swap/loss bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         wr_addr        <= '0;
         pending        <= 1'b0;
         disp_bank      <= 1'b0;
         frame_swap     <= 1'b0;
         gb_on          <= 1'b0;
         frames_dropped <= '0;
         idle_cnt       <= '0;
      end else begin
         state      <= state_nx;
         if (we) wr_addr <= waddr + 1'b1;
         pending    <= (pending | set_pend) & ~do_swap & ~lost;
         disp_bank  <= disp_bank ^ do_swap;
         frame_swap <= do_swap;
         gb_on      <= lost ? 1'b0 : (gb_on | do_swap);
         if (drop && frames_dropped != 8'hff) frames_dropped <= frames_dropped + 1'b1;
         idle_cnt   <= strobe ? '0 : (idle_cnt == CW'(TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;
      end
   end

   // two banks in one array: writer owns the back bank, reader the display bank
   always_ff @(posedge clk) begin
      if (we && !reset) mem[{~disp_bank, waddr}] <= dat_s2;
      rd_q <= mem[{disp_bank, rd_addr}];
   end

   assign dx   = vga.vga_x - 10'(OFF_X);
   assign dy   = vga.vga_y - 10'(OFF_Y);
   assign sx   = dx >> SH;
   assign sy   = dy >> SH;
   assign in_x = (vga.vga_x >= 10'(OFF_X)) && (vga.vga_x < 10'(OFF_X + SRC_H*SCALE));
   assign in_y = (vga.vga_y >= 10'(OFF_Y)) && (vga.vga_y < 10'(OFF_Y + SRC_V*SCALE));

   // two-stage read pipeline: address/flags, then registered bank data
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr <= '0;
         {win1, chk1, on1, act1} <= '0;
         {win2, chk2, on2, act2} <= '0;
      end else begin
         rd_addr <= ADDR_W'(int'(sy) * SRC_H + int'(sx));
         win1    <= vga.vga_active & in_x & in_y;
         chk1    <= sx[3] ^ sy[3];
         on1     <= gb_on;
         act1    <= vga.vga_active;
         {win2, chk2, on2, act2} <= {win1, chk1, on1, act1};
      end
   end

   assign vga.pixel_out       = !win2 ? '0 : on2 ? rd_q : {PX_W{chk2}};
   assign vga.pixel_in_window = win2;
   assign vga.pixel_active    = act2;
endmodule
